// File: rtl/k2_sched_pkg.sv
// Shared types and width helpers for the K2 program scheduler and its arbiter.
package k2_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_BITS       = 8;
  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_RST_CYC    = 2;
  localparam int unsigned DEF_STABLE_CYC = 4;
  localparam int unsigned DEF_MAX_CYC    = 200;

  // Width of a counter that must hold 0..maxval without wrapping.
  function automatic int unsigned cnt_w(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import k2_sched_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin : pick
    logic             found;
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    cand  = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = IDX_W'((32'(ptr_i) + 32'(k)) % N);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/k2_program_scheduler.sv
// Time-shares one K2 processor among NREQ requesters: arbitrate, flush, run,
// detect halt (address stuck) or timeout, and hand Ro back to the owner.
module k2_program_scheduler
  import k2_sched_pkg::*;
#(
  parameter int unsigned BITS       = DEF_BITS,
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned RST_CYC    = DEF_RST_CYC,
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned MAX_CYC    = DEF_MAX_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   prog_sel,
  output logic                      proc_rst_n,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [BITS-1:0]           proc_ro,
  output logic                      busy,
  output logic [NREQ-1:0]           done,
  output logic [BITS-1:0]           result,
  output logic                      timeout
);

  localparam int unsigned SEL_W = idx_w(NREQ);
  localparam int unsigned CYC_W = cnt_w(MAX_CYC);
  localparam int unsigned STB_W = cnt_w(STABLE_CYC);
  localparam int unsigned RC_W  = cnt_w(RST_CYC);

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic                prn_q, prn_d;
  logic                busy_q, busy_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [BITS-1:0]     result_q, result_d;
  logic                to_q, to_d;
  logic [RC_W-1:0]     rcnt_q, rcnt_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [STB_W-1:0]    stb_q, stb_d;
  logic [ADDR_W-1:0]   prev_q, prev_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;
  logic                halt, to_hit;

  rr_arbiter #(.N(NREQ), .IDX_W(SEL_W)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign halt   = (stb_q == STB_W'(STABLE_CYC - 1)) && (prog_addr == prev_q);
  assign to_hit = (cyc_q == CYC_W'(MAX_CYC - 1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    done_d   = '0;
    result_d = result_q;
    to_d     = to_q;
    rcnt_d   = rcnt_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    prev_d   = prev_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_gnt;
          sel_d   = arb_idx;
          ptr_d   = (arb_idx == SEL_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          rcnt_d  = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (rcnt_q == RC_W'(RST_CYC - 1)) begin
          cyc_d   = '0;
          stb_d   = '0;
          prev_d  = prog_addr;
          state_d = RUN;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RUN: begin
        cyc_d  = cyc_q + 1'b1;
        prev_d = prog_addr;
        stb_d  = (prog_addr == prev_q) ? stb_q + 1'b1 : '0;
        // A halt seen on the budget's last cycle still counts as a clean halt.
        if (halt || to_hit) begin
          result_d = proc_ro;
          to_d     = to_hit & ~halt;
          done_d   = grant_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    prn_d  = (state_d == RUN);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      prn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      result_q <= '0;
      to_q     <= 1'b0;
      rcnt_q   <= '0;
      cyc_q    <= '0;
      stb_q    <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      prn_q    <= prn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      to_q     <= to_d;
      rcnt_q   <= rcnt_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      prev_q   <= prev_d;
    end
  end

  assign grant      = grant_q;
  assign prog_sel   = sel_q;
  assign proc_rst_n = prn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign timeout    = to_q;

endmodule
